// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU requester, debug requester and the
// single-port data memory. The arbiter connects through the slave
// modport; the requester/memory side uses the master modport.
// Optional statistics outputs exist only when DMEM_ARB_STATS_EN is defined.
interface dmem_arbiter_if #(
   parameter int unsigned AW = 5
);
   logic          cpu_req_i;
   logic          cpu_we_i;
   logic [AW-1:0] cpu_addr_i;
   logic [31:0]   cpu_wdata_i;
   logic [31:0]   cpu_rdata_o;
   logic          cpu_ack_o;
   logic          cpu_stall_o;

   logic          dbg_req_i;
   logic          dbg_we_i;
   logic [AW-1:0] dbg_addr_i;
   logic [31:0]   dbg_wdata_i;
   logic [31:0]   dbg_rdata_o;
   logic          dbg_ack_o;

   logic          mem_en_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_wdata_o;
   logic [31:0]   mem_rdata_i;

`ifdef DMEM_ARB_STATS_EN
   logic [15:0]   cpu_grant_cnt_o;
   logic [15:0]   dbg_grant_cnt_o;
   logic [15:0]   conflict_cnt_o;
`endif

   modport slave (
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
      input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
      input  mem_rdata_i,
      output cpu_rdata_o, cpu_ack_o, cpu_stall_o,
      output dbg_rdata_o, dbg_ack_o,
      output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
`ifdef DMEM_ARB_STATS_EN
      , output cpu_grant_cnt_o, dbg_grant_cnt_o, conflict_cnt_o
`endif
   );

   modport master (
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
      output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
      output mem_rdata_i,
      input  cpu_rdata_o, cpu_ack_o, cpu_stall_o,
      input  dbg_rdata_o, dbg_ack_o,
      input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
`ifdef DMEM_ARB_STATS_EN
      , input cpu_grant_cnt_o, dbg_grant_cnt_o, conflict_cnt_o
`endif
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one fixed-latency single-port memory between
// the CPU MEM stage and a debug/loader port. One access in flight at a time,
// sequenced IDLE -> ISSUE -> WAIT -> DONE. CPU wins ties unless the debug
// port has lost STARVE_MAX consecutive arbitrations.
// Define DMEM_ARB_STATS_EN to add grant/conflict counters on the interface.
module dmem_arbiter #(
   parameter int unsigned AW         = 5,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic           clk_i,
   input logic           rst_i,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state;
   logic          owner_dbg;
   logic [2:0]    wait_cnt;
   logic [3:0]    starve_cnt;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   cpu_rdata;
   logic [31:0]   dbg_rdata;
   logic          cpu_ack;
   logic          dbg_ack;

   logic          any_req;
   logic          both_req;
   logic          grant_dbg;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [31:0]   sel_wdata;

   // arbitration decision and selected request fields for the IDLE grant
   always_comb begin
      any_req   = bus.cpu_req_i | bus.dbg_req_i;
      both_req  = bus.cpu_req_i & bus.dbg_req_i;
      grant_dbg = bus.dbg_req_i &
                  (~bus.cpu_req_i | (starve_cnt >= 4'(STARVE_MAX)));
      sel_we    = grant_dbg ? bus.dbg_we_i    : bus.cpu_we_i;
      sel_addr  = grant_dbg ? bus.dbg_addr_i  : bus.cpu_addr_i;
      sel_wdata = grant_dbg ? bus.dbg_wdata_i : bus.cpu_wdata_i;
   end

   // access sequencer with registered memory strobes, read data and acks;
   // the memory command registers double as the latched request fields,
   // so they are loaded on the grant and cleared once ISSUE has passed
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= IDLE;
         owner_dbg  <= 1'b0;
         wait_cnt   <= '0;
         starve_cnt <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_rdata  <= '0;
         dbg_rdata  <= '0;
         cpu_ack    <= 1'b0;
         dbg_ack    <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         dbg_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (!bus.dbg_req_i) begin
                  starve_cnt <= '0;
               end
               if (any_req) begin
                  owner_dbg <= grant_dbg;
                  mem_en    <= 1'b1;
                  mem_we    <= sel_we;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  if (grant_dbg) begin
                     starve_cnt <= '0;
                  end else if (bus.dbg_req_i && (starve_cnt != 4'hF)) begin
                     starve_cnt <= starve_cnt + 4'd1;
                  end
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               mem_en    <= 1'b0;
               mem_we    <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               wait_cnt  <= 3'(MEM_LAT);
               state     <= WAIT;
            end
            WAIT: begin
               // last WAIT cycle is MEM_LAT cycles after ISSUE: data valid now
               if (wait_cnt == 3'd1) begin
                  wait_cnt <= '0;
                  if (owner_dbg) begin
                     dbg_rdata <= bus.mem_rdata_i;
                     dbg_ack   <= 1'b1;
                  end else begin
                     cpu_rdata <= bus.mem_rdata_i;
                     cpu_ack   <= 1'b1;
                  end
                  state <= DONE;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_en_o    = mem_en;
   assign bus.mem_we_o    = mem_we;
   assign bus.mem_addr_o  = mem_addr;
   assign bus.mem_wdata_o = mem_wdata;
   assign bus.cpu_rdata_o = cpu_rdata;
   assign bus.cpu_ack_o   = cpu_ack;
   assign bus.dbg_rdata_o = dbg_rdata;
   assign bus.dbg_ack_o   = dbg_ack;
   assign bus.cpu_stall_o = bus.cpu_req_i & ~cpu_ack;

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] cpu_grant_cnt;
   logic [15:0] dbg_grant_cnt;
   logic [15:0] conflict_cnt;

   // wrapping counters of grants per requester and contended IDLE cycles
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cpu_grant_cnt <= '0;
         dbg_grant_cnt <= '0;
         conflict_cnt  <= '0;
      end else if (state == IDLE) begin
         if (any_req) begin
            if (grant_dbg) begin
               dbg_grant_cnt <= dbg_grant_cnt + 16'd1;
            end else begin
               cpu_grant_cnt <= cpu_grant_cnt + 16'd1;
            end
         end
         if (both_req) begin
            conflict_cnt <= conflict_cnt + 16'd1;
         end
      end
   end

   assign bus.cpu_grant_cnt_o = cpu_grant_cnt;
   assign bus.dbg_grant_cnt_o = dbg_grant_cnt;
   assign bus.conflict_cnt_o  = conflict_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: requester drivers push expected
// transactions into per-requester queues; a negedge monitor predicts each
// grant from the arbitration rules and checks fields, timing and read data.
module tb_dmem_arbiter;
   localparam int unsigned AW         = 5;
   localparam int unsigned MEM_LAT    = 3;
   localparam int unsigned STARVE_MAX = 4;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      logic [31:0]   rdata;
   } txn_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.AW(AW)) bus ();

   dmem_arbiter #(
      .AW(AW),
      .MEM_LAT(MEM_LAT),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus(bus.slave)
   );

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_val(input int unsigned i);
      return (i == 3) ? 32'h0000_00A5 : (32'(i) * 32'h0101_0107 + 32'h5A5A_0000);
   endfunction

   // memory model: fixed latency, junk on the read bus outside valid cycles
   logic [31:0] mem_arr [32];
   logic [31:0] rd_pipe [MEM_LAT];
   logic        mem_load;
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 32; i++) mem_arr[i] <= init_val(i);
      end else if (bus.mem_en_o && bus.mem_we_o) begin
         mem_arr[bus.mem_addr_o] <= bus.mem_wdata_o;
      end
      rd_pipe[0] <= bus.mem_en_o ? mem_arr[bus.mem_addr_o] : $urandom();
      for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.mem_rdata_i = rd_pipe[MEM_LAT-1];

   logic [31:0] ref_mem [32];
   txn_t        cpu_q[$];
   txn_t        dbg_q[$];
   bit          grant_log[$];
   int unsigned en_log[$];

   // monitor / scoreboard
   int unsigned cyc = 0;
   bit          pending = 0;
   bit          pend_dbg = 0;
   int unsigned en_cyc = 0;
   int unsigned losses = 0;
   logic        prev_cpu = 0;
   logic        prev_dbg = 0;
   always @(negedge clk) begin
      txn_t  t;
      bit    exp_dbg;
      bit    ack_dbg;
      logic [31:0] rst_or;
      if (!rst) begin
         rst_or = bus.cpu_rdata_o | bus.dbg_rdata_o | 32'(bus.mem_addr_o) | bus.mem_wdata_o |
                  {28'd0, bus.cpu_ack_o, bus.dbg_ack_o, bus.mem_en_o, bus.mem_we_o};
`ifdef DMEM_ARB_STATS_EN
         rst_or = rst_or | {bus.cpu_grant_cnt_o, bus.dbg_grant_cnt_o} | 32'(bus.conflict_cnt_o);
`endif
         chk("rst_outputs_zero", rst_or, 32'd0);
         chk("rst_stall", bus.cpu_stall_o, bus.cpu_req_i);
         pending = 0;
         losses  = 0;
      end else begin
         cyc++;
         chk("stall", bus.cpu_stall_o, bus.cpu_req_i & ~bus.cpu_ack_o);
         if (bus.cpu_ack_o || bus.dbg_ack_o) begin
            ack_dbg = bus.dbg_ack_o;
            chk("ack_unique", bus.cpu_ack_o & bus.dbg_ack_o, 0);
            chk("ack_expected", pending, 1);
            if (pending) begin
               chk("ack_owner", ack_dbg, pend_dbg);
               chk("ack_latency", cyc - en_cyc, MEM_LAT + 1);
            end
            grant_log.push_back(ack_dbg);
            chk("ack_queue_nonempty", (ack_dbg ? dbg_q.size() : cpu_q.size()) != 0, 1);
            if (ack_dbg && dbg_q.size() != 0) begin
               t = dbg_q.pop_front();
               if (!t.we) chk("dbg_rdata", bus.dbg_rdata_o, t.rdata);
            end else if (!ack_dbg && cpu_q.size() != 0) begin
               t = cpu_q.pop_front();
               if (!t.we) chk("cpu_rdata", bus.cpu_rdata_o, t.rdata);
            end
            pending = 0;
         end
         if (pending && (cyc - en_cyc > MEM_LAT + 1)) begin
            chk("ack_missing", cyc - en_cyc, MEM_LAT + 1);
            pending = 0;
         end
         if (bus.mem_en_o) begin
            chk("single_outstanding", pending, 0);
            chk("grant_had_request", prev_cpu | prev_dbg, 1);
            exp_dbg = prev_dbg && (!prev_cpu || losses >= STARVE_MAX);
            chk("grant_queue_nonempty", (exp_dbg ? dbg_q.size() : cpu_q.size()) != 0, 1);
            if ((exp_dbg ? dbg_q.size() : cpu_q.size()) != 0) begin
               t = exp_dbg ? dbg_q[0] : cpu_q[0];
               chk("mem_addr", bus.mem_addr_o, t.addr);
               chk("mem_we", bus.mem_we_o, t.we);
               if (t.we) chk("mem_wdata", bus.mem_wdata_o, t.wdata);
            end
            if (exp_dbg)       losses = 0;
            else if (prev_dbg) losses = (losses < 15) ? losses + 1 : 15;
            else               losses = 0;
            en_log.push_back(cyc);
            pending  = 1;
            pend_dbg = exp_dbg;
            en_cyc   = cyc;
         end
      end
      prev_cpu = bus.cpu_req_i;
      prev_dbg = bus.dbg_req_i;
   end

   // drivers
   task automatic req_start(input bit d, input logic we, input logic [AW-1:0] a,
                            input logic [31:0] wd);
      txn_t t;
      t.we = we; t.addr = a; t.wdata = wd; t.rdata = ref_mem[a];
      if (we) ref_mem[a] = wd;
      if (d) begin
         dbg_q.push_back(t);
         bus.dbg_we_i = we; bus.dbg_addr_i = a; bus.dbg_wdata_i = wd; bus.dbg_req_i = 1'b1;
      end else begin
         cpu_q.push_back(t);
         bus.cpu_we_i = we; bus.cpu_addr_i = a; bus.cpu_wdata_i = wd; bus.cpu_req_i = 1'b1;
      end
   endtask

   task automatic req_wait(input bit d, output int unsigned n);
      bit done = 0;
      n = 0;
      while (!done) begin
         @(negedge clk);
         if (d ? bus.dbg_ack_o : bus.cpu_ack_o) begin
            done = 1;
         end else begin
            n++;
            if (n > 300) begin
               chk(d ? "dbg_ack_timeout" : "cpu_ack_timeout", n, MEM_LAT + 2);
               done = 1;
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic req_idle(input bit d);
      if (d) bus.dbg_req_i = 1'b0;
      else   bus.cpu_req_i = 1'b0;
   endtask

   task automatic cont_run(input bit d, input int unsigned n);
      int unsigned w;
      for (int unsigned i = 0; i < n; i++) begin
         req_start(d, 1'b0, AW'(d ? 16 + $urandom_range(15) : $urandom_range(15)), 32'd0);
         req_wait(d, w);
      end
      req_idle(d);
   endtask

   task automatic rand_run(input bit d, input int unsigned n);
      int unsigned w;
      int unsigned gap;
      for (int unsigned i = 0; i < n; i++) begin
         req_start(d, 1'($urandom_range(1)),
                   AW'(d ? 16 + $urandom_range(15) : $urandom_range(15)), $urandom());
         req_wait(d, w);
         gap = $urandom_range(3);
         if (gap != 0) begin
            req_idle(d);
            repeat (gap) begin @(posedge clk); #1; end
         end
      end
      req_idle(d);
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      bus.cpu_req_i = 1'b0;
      bus.dbg_req_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      cpu_q.delete();
      dbg_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, actual running required finished");
      n_bad++;
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned w;
      int unsigned n;
      bus.cpu_req_i = 0; bus.cpu_we_i = 0; bus.cpu_addr_i = '0; bus.cpu_wdata_i = '0;
      bus.dbg_req_i = 0; bus.dbg_we_i = 0; bus.dbg_addr_i = '0; bus.dbg_wdata_i = '0;
      for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
      mem_load = 1'b1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      mem_load = 1'b0;
      chk("reset_cpu_ack", bus.cpu_ack_o, 0);
      chk("reset_mem_en", bus.mem_en_o, 0);

      // single CPU read of word 3
      req_start(0, 1'b0, 5'd3, 32'd0);
      req_wait(0, w);
      chk("t1_latency", w, MEM_LAT + 2);
      chk("t1_cpu_rdata", bus.cpu_rdata_o, 32'h0000_00A5);
      req_idle(0);

      // CPU write then debug read of the same word
      req_start(0, 1'b1, 5'd7, 32'h0000_1234);
      req_wait(0, w);
      req_idle(0);
      req_start(1, 1'b0, 5'd7, 32'd0);
      req_wait(1, w);
      chk("t2_dbg_rdata", bus.dbg_rdata_o, 32'h0000_1234);
      req_idle(1);

      // continuous contention: CPU x4 then DBG, repeating
      grant_log.delete();
      fork
         cont_run(0, 15);
         cont_run(1, 3);
      join
      chk("t3_grant_count", grant_log.size(), 18);
      for (int unsigned i = 0; i < 15; i++) begin
         if (i < grant_log.size()) chk("t3_grant_order", grant_log[i], (i % 5) == 4);
      end

      // back-to-back CPU reads: access spacing MEM_LAT+3
      repeat (2) begin @(posedge clk); #1; end
      en_log.delete();
      cont_run(0, 3);
      chk("t4_en_count", en_log.size(), 3);
      for (int unsigned i = 1; i < 3; i++) begin
         if (i < en_log.size()) chk("t4_en_spacing", en_log[i] - en_log[i-1], MEM_LAT + 3);
      end

      // reset during WAIT of a debug read
      req_start(1, 1'b0, 5'd20, 32'd0);
      n = 0;
      while (!bus.mem_en_o && n < 50) begin @(negedge clk); n++; end
      chk("t5_saw_issue", bus.mem_en_o, 1);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("t5_dbg_ack", bus.dbg_ack_o, 0);
      chk("t5_dbg_rdata", bus.dbg_rdata_o, 32'd0);
      chk("t5_cpu_rdata", bus.cpu_rdata_o, 32'd0);
      chk("t5_mem_en", bus.mem_en_o, 0);
      bus.dbg_req_i = 1'b0;
      bus.cpu_req_i = 1'b1;
      @(posedge clk); #1;
      bus.cpu_req_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      cpu_q.delete();
      dbg_q.delete();
      req_start(0, 1'b0, 5'd3, 32'd0);
      req_wait(0, w);
      chk("t5_latency", w, MEM_LAT + 2);
      chk("t5_cpu_rdata_after", bus.cpu_rdata_o, 32'h0000_00A5);
      req_idle(0);

      // random mixed traffic, disjoint address halves per requester
      fork
         rand_run(0, 40);
         rand_run(1, 40);
      join

`ifdef DMEM_ARB_STATS_EN
      apply_reset();
      fork
         cont_run(0, 5);
         begin
            req_start(1, 1'b0, 5'd17, 32'd0);
            req_wait(1, w);
            chk("stats_cpu_grants", bus.cpu_grant_cnt_o, 4);
            chk("stats_dbg_grants", bus.dbg_grant_cnt_o, 1);
            chk("stats_conflicts", bus.conflict_cnt_o, 5);
            req_idle(1);
         end
      join
`endif

      repeat (6) @(posedge clk);
      chk("cpu_queue_drained", cpu_q.size(), 0);
      chk("dbg_queue_drained", dbg_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the pipelined CPU's single-port data memory between two requesters: the CPU MEM stage and a debug/loader port used for memory preload and end-of-run dumps.
- Serialises accesses through a fixed-latency memory and returns read data and a one-cycle ack to the owner.
- Stalls the pipeline while a CPU access is outstanding.
- Bounds debug-port starvation with an aging counter.

Parameters:
- AW, 5, word-address width (DM depth 2^AW words).
- MEM_LAT, 1, cycles from mem_en_o to valid mem_rdata_i; legal range 1..7.
- STARVE_MAX, 4, consecutive lost arbitrations before debug is forced ahead of CPU; legal range 1..15.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- cpu_req_i  in  1  CPU access request.
- cpu_we_i  in  1  CPU write (1) / read (0).
- cpu_addr_i  in  AW  CPU word address.
- cpu_wdata_i  in  32  CPU write data.
- cpu_rdata_o  out  32  CPU read data; valid while cpu_ack_o=1.
- cpu_ack_o  out  1  one-cycle completion pulse to CPU.
- cpu_stall_o  out  1  combinational: cpu_req_i & ~cpu_ack_o.
- dbg_req_i, dbg_we_i, dbg_addr_i[AW], dbg_wdata_i[32]  in  debug request fields; same meaning as the CPU fields.
- dbg_rdata_o  out  32  debug read data.
- dbg_ack_o  out  1  debug completion pulse.
- mem_en_o  out  1  memory access strobe, one cycle per access.
- mem_we_o  out  1  memory write enable, qualified by mem_en_o.
- mem_addr_o  out  AW  memory address.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data.

Behaviour:
- Reset (rst_i=0, asynchronous): state IDLE, owner CPU, starve_cnt 0; every output 0 except cpu_stall_o, which follows cpu_req_i. An in-flight access is dropped with no ack.
- FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - Samples requests. If none, stay.
  - If only one requester, grant it.
  - If both request: grant debug if starve_cnt >= STARVE_MAX, else grant CPU.
  - Latch owner and request fields into registers. Next state ISSUE.
- ISSUE: mem_en_o=1, with mem_we_o/addr/wdata taken from the latched fields. Load wait counter with MEM_LAT. Next state WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 0 (MEM_LAT cycles after ISSUE), register mem_rdata_i into the owner's rdata_o. Next state DONE.
- DONE: owner's ack_o=1 for exactly one cycle; rdata_o holds its value until the next ack to that owner. Next state IDLE. Requests are not sampled in DONE.
- Latency:
  - Ack appears MEM_LAT+2 cycles after the request is first sampled in IDLE.
  - Throughput is one access per MEM_LAT+3 cycles.
  - Reads and writes have identical timing. On writes, rdata_o is updated with mem_rdata_i (don't-care content).
- Requester rules:
  - Hold req and fields stable from assertion until ack.
  - In the cycle after ack, either deassert req or present the next transaction.
  - Changing fields before ack is illegal; the latched copy is used.
- Aging counter:
  - starve_cnt increments, saturating at 15, on each IDLE grant to CPU while dbg_req_i=1.
  - Clears on a debug grant, or on any IDLE cycle with dbg_req_i=0.
- Only one transaction is outstanding at any time. mem_en_o is never asserted outside ISSUE.
- Simultaneous requests arriving while busy wait in IDLE arbitration; no queuing beyond the request lines.

Optional Feature:
- DMEM_ARB_STATS_EN defined: adds outputs cpu_grant_cnt_o[15:0], dbg_grant_cnt_o[15:0] and conflict_cnt_o[15:0].
  - cpu_grant_cnt_o and dbg_grant_cnt_o increment on each grant to the respective requester.
  - conflict_cnt_o increments on each IDLE cycle where both req=1.
  - All three wrap at 2^16 and reset to 0.
- Not defined: these ports and counters are absent; functional behaviour is otherwise identical.

Test Plan:
- Reset then single CPU read, MEM_LAT=1, addr 3, memory word 3 = 0x0000_00A5 -> mem_en_o pulses one cycle with mem_addr_o=3; cpu_ack_o 3 cycles after first IDLE sample; cpu_rdata_o=0xA5; cpu_stall_o=1 until the ack cycle.
- CPU write addr 7 data 0x1234, then debug read addr 7 -> mem_we_o=1 only in the write ISSUE cycle; dbg_rdata_o=0x1234; no cpu_ack_o during the debug transaction.
- Both requesting continuously, STARVE_MAX=4 -> grant order CPU,CPU,CPU,CPU,DBG, repeating; starve_cnt returns to 0 after each DBG grant.
- MEM_LAT=3 back-to-back CPU reads -> consecutive mem_en_o pulses exactly 6 cycles apart; each ack is exactly one cycle wide.
- Assert rst_i=0 during WAIT of a debug read -> outputs 0 immediately with no dbg_ack_o. After release, a fresh CPU request completes normally.
- With DMEM_ARB_STATS_EN, run 5 conflicting arbitrations (STARVE_MAX=4) -> cpu_grant_cnt_o=4, dbg_grant_cnt_o=1, conflict_cnt_o>=5.
